// File: rtl/mix_rom_arbiter_pkg.sv
// Shared constants and types for the mix multiplier ROM arbiter.
package mix_arb_pkg;
  localparam int MIX_ROM_ADDR_W = 6;
  localparam int MIX_ROM_DATA_W = 9;
  localparam int MIX_MAX_REQ    = 4;
  localparam int MIX_IDX_W      = $clog2(MIX_MAX_REQ);

  typedef logic [MIX_ROM_ADDR_W-1:0] mix_addr_t;
  typedef logic [MIX_ROM_DATA_W-1:0] mix_data_t;
  typedef logic [MIX_IDX_W-1:0]      mix_idx_t;
endpackage

// File: rtl/mix_rom_arbiter_if.sv
// Requester/ROM bus of the mix ROM arbiter; master = players + ROM, slave = arbiter.
interface mix_rom_arbiter_if #(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = 6,
  parameter int DATA_W  = 9
);
  // Handshake: requester i holds req[i] and its addr_in slice stable until grant[i]
  // pulses; rvalid[i] follows grant[i] by one cycle, with rdata valid only then.
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*ADDR_W-1:0] addr_in;
  logic [NUM_REQ-1:0]        grant;
  logic [NUM_REQ-1:0]        rvalid;
  logic [DATA_W-1:0]         rdata;
  logic [ADDR_W-1:0]         rom_addr;
  logic [DATA_W-1:0]         rom_dout;

  modport master (output req, addr_in, rom_dout, input grant, rvalid, rdata, rom_addr);
  modport slave  (input req, addr_in, rom_dout, output grant, rvalid, rdata, rom_addr);
endinterface

// File: rtl/mix_rom_arbiter_rr_pick.sv
// Combinational round-robin select: first set req bit searching cyclically from last+1.
module mix_rr_pick
  import mix_arb_pkg::*;
#(
  parameter int NUM_REQ = 3
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  mix_idx_t           last_i,
  output mix_idx_t           winner_o,
  output logic               any_req_o
);
  int       sum;
  mix_idx_t idx;

  always_comb begin
    winner_o  = last_i;
    any_req_o = 1'b0;
    sum       = 0;
    idx       = '0;
    // Walk from the farthest candidate to the nearest so the nearest hit wins.
    for (int k = NUM_REQ; k >= 1; k--) begin
      sum = int'(last_i) + k;
      if (sum >= NUM_REQ) sum = sum - NUM_REQ;
      idx = mix_idx_t'(sum);
      if (req_i[idx]) begin
        winner_o  = idx;
        any_req_o = 1'b1;
      end
    end
  end
endmodule

// File: rtl/mix_rom_arbiter.sv
// Round-robin arbiter sharing one synchronous mix ROM; optional MIX_ARB_GRANT_CNT_EN adds grant counters.
module mix_rom_arbiter
  import mix_arb_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = MIX_ROM_ADDR_W,
  parameter int DATA_W  = MIX_ROM_DATA_W
) (
  input  logic                    clk,
  input  logic                    reset,
  mix_rom_arbiter_if.slave        bus,
  output mix_idx_t                dbg_last_o
`ifdef MIX_ARB_GRANT_CNT_EN
  ,
  output logic [NUM_REQ*16-1:0]   grant_cnt
`endif
);
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [NUM_REQ-1:0] rvalid_q, rvalid_d;
  logic [ADDR_W-1:0]  rom_addr_q, rom_addr_d;
  mix_idx_t           last_q, last_d;
  mix_idx_t           winner;
  logic               any_req;

  mix_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req_i     (bus.req),
    .last_i    (last_q),
    .winner_o  (winner),
    .any_req_o (any_req)
  );

  always_comb begin
    grant_d    = '0;
    rom_addr_d = rom_addr_q;
    last_d     = last_q;
    rvalid_d   = grant_q;
    if (any_req) begin
      grant_d[winner] = 1'b1;
      rom_addr_d      = bus.addr_in[winner*ADDR_W +: ADDR_W];
      last_d          = winner;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      grant_q    <= '0;
      rvalid_q   <= '0;
      rom_addr_q <= '0;
      last_q     <= mix_idx_t'(NUM_REQ - 1);
    end else begin
      grant_q    <= grant_d;
      rvalid_q   <= rvalid_d;
      rom_addr_q <= rom_addr_d;
      last_q     <= last_d;
    end
  end

  assign bus.grant    = grant_q;
  assign bus.rvalid   = rvalid_q;
  assign bus.rom_addr = rom_addr_q;
  // The ROM output register already lines up with rvalid, so data is a pass-through.
  assign bus.rdata    = bus.rom_dout;
  assign dbg_last_o   = last_q;

`ifdef MIX_ARB_GRANT_CNT_EN
  logic [15:0] cnt_q [NUM_REQ];

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REQ; i++) begin
      if (reset) begin
        cnt_q[i] <= '0;
      end else if (grant_d[i] && (cnt_q[i] != 16'hFFFF)) begin
        cnt_q[i] <= cnt_q[i] + 16'd1;
      end
    end
  end

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_cnt
    assign grant_cnt[g*16 +: 16] = cnt_q[g];
  end
`endif
endmodule

// File: tb/tb_mix_rom_arbiter.sv
// Self-checking bench for mix_rom_arbiter: vector table plus hand-written fairness/counter sequences.
module tb_mix_rom_arbiter;
  import mix_arb_pkg::*;

  localparam int NUM_REQ = 3;

  logic     clk = 1'b0;
  logic     reset;
  mix_idx_t dbg_last;
`ifdef MIX_ARB_GRANT_CNT_EN
  logic [NUM_REQ*16-1:0] grant_cnt;
`endif

  mix_rom_arbiter_if #(.NUM_REQ(NUM_REQ), .ADDR_W(MIX_ROM_ADDR_W), .DATA_W(MIX_ROM_DATA_W)) bus ();

  mix_rom_arbiter #(.NUM_REQ(NUM_REQ)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .dbg_last_o (dbg_last)
`ifdef MIX_ARB_GRANT_CNT_EN
    ,
    .grant_cnt  (grant_cnt)
`endif
  );

  // clock / reset
  always #5 clk = ~clk;

  // ROM contents model: distinct values per address
  function automatic mix_data_t rom_val(input mix_addr_t a);
    return {a[2:0], a} ^ 9'h0A5;
  endfunction

  always_ff @(posedge clk) bus.rom_dout <= rom_val(bus.rom_addr);

  int n_checks = 0;
  int n_fail   = 0;
  logic [MIX_ROM_DATA_W-1:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic drive(input logic rst, input logic [2:0] req,
                       input mix_addr_t a0, input mix_addr_t a1, input mix_addr_t a2);
    reset       = rst;
    bus.req     = req;
    bus.addr_in = {a2, a1, a0};
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic      rst;
    logic [2:0] req;
    mix_addr_t a0, a1, a2;
    logic [2:0] g, rv;
    mix_addr_t ra;
    mix_data_t rd;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic rst, input logic [2:0] req,
                              input mix_addr_t a0, input mix_addr_t a1, input mix_addr_t a2,
                              input logic [2:0] g, input logic [2:0] rv,
                              input mix_addr_t ra, input mix_addr_t rd_a);
    vec_t v;
    v.rst = rst; v.req = req; v.a0 = a0; v.a1 = a1; v.a2 = a2;
    v.g = g; v.rv = rv; v.ra = ra; v.rd = rom_val(rd_a);
    vecs.push_back(v);
  endfunction

  initial begin
    mix_addr_t rr_addr [3];
    int rv_cnt [3];
    logic [2:0] eg, erv;

    drive(1'b1, 3'b000, 6'd0, 6'd0, 6'd0);
    step();

    // reset, single request from 0
    add(1, 3'b000, 0, 0, 0,   3'b000, 3'b000, 0, 0);
    add(0, 3'b001, 0, 0, 0,   3'b001, 3'b000, 0, 0);
    add(0, 3'b000, 0, 0, 0,   3'b000, 3'b001, 0, 0);
    add(0, 3'b000, 0, 0, 0,   3'b000, 3'b000, 0, 0);
    // req0 and req2 together after reset
    add(1, 3'b000, 0, 0, 0,   3'b000, 3'b000, 0, 0);
    add(0, 3'b101, 1, 0, 31,  3'b001, 3'b000, 1, 0);
    add(0, 3'b100, 1, 0, 31,  3'b100, 3'b001, 31, 1);
    add(0, 3'b000, 1, 0, 31,  3'b000, 3'b100, 31, 31);
    add(0, 3'b000, 1, 0, 31,  3'b000, 3'b000, 31, 0);
    // all three held for nine cycles, pointer at 2
    rr_addr[0] = 10; rr_addr[1] = 20; rr_addr[2] = 30;
    for (int k = 0; k < 9; k++) begin
      add(0, 3'b111, 10, 20, 30, 3'(1 << (k % 3)),
          (k == 0) ? 3'b000 : 3'(1 << ((k + 2) % 3)),
          rr_addr[k % 3], (k == 0) ? 6'd0 : rr_addr[(k + 2) % 3]);
    end
    add(0, 3'b000, 10, 20, 30, 3'b000, 3'b100, 30, 30);
    // requester 1 alone, address advancing per grant
    add(0, 3'b010, 0, 5, 0,   3'b010, 3'b000, 5, 0);
    add(0, 3'b010, 0, 6, 0,   3'b010, 3'b010, 6, 5);
    add(0, 3'b010, 0, 7, 0,   3'b010, 3'b010, 7, 6);
    add(0, 3'b000, 0, 7, 0,   3'b000, 3'b010, 7, 7);
    add(0, 3'b000, 0, 7, 0,   3'b000, 3'b000, 7, 0);
    // reset in the grant cycle cancels rvalid; pointer back to 2
    add(0, 3'b001, 3, 0, 0,   3'b001, 3'b000, 3, 0);
    add(1, 3'b110, 3, 9, 12,  3'b000, 3'b000, 0, 0);
    add(0, 3'b110, 3, 9, 12,  3'b010, 3'b000, 9, 0);
    add(0, 3'b100, 3, 9, 12,  3'b100, 3'b010, 12, 9);
    add(0, 3'b000, 3, 9, 12,  3'b000, 3'b100, 12, 12);
    // address change while waiting: value at the granting edge is used
    add(0, 3'b011, 40, 41, 0, 3'b001, 3'b000, 40, 0);
    add(0, 3'b010, 40, 42, 0, 3'b010, 3'b001, 42, 40);
    add(0, 3'b000, 40, 42, 0, 3'b000, 3'b010, 42, 42);

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].req, vecs[i].a0, vecs[i].a1, vecs[i].a2);
      step();
      chk($sformatf("v%0d grant", i),    32'(bus.grant),    32'(vecs[i].g));
      chk($sformatf("v%0d rvalid", i),   32'(bus.rvalid),   32'(vecs[i].rv));
      chk($sformatf("v%0d rom_addr", i), 32'(bus.rom_addr), 32'(vecs[i].ra));
      if (vecs[i].rv != 3'b000)
        chk($sformatf("v%0d rdata", i),  32'(bus.rdata),    32'(vecs[i].rd));
    end

    // fairness with scoreboard queue: all held six cycles from pointer 2
    drive(1'b1, 3'b000, 0, 0, 0);
    step();
    rv_cnt = '{0, 0, 0};
    for (int c = 0; c < 8; c++) begin
      drive(1'b0, (c < 6) ? 3'b111 : 3'b000, 50, 51, 52);
      step();
      eg = (c < 6) ? 3'(1 << (c % 3)) : 3'b000;
      chk($sformatf("rr%0d grant", c), 32'(bus.grant), 32'(eg));
      chk($sformatf("rr%0d onehot", c), 32'($countones(bus.grant) <= 1 && $countones(bus.rvalid) <= 1), 32'd1);
      if (c < 6) exp_q.push_back(rom_val(mix_addr_t'(50 + c % 3)));
      erv = (c >= 1 && c < 7) ? 3'(1 << ((c - 1) % 3)) : 3'b000;
      chk($sformatf("rr%0d rvalid", c), 32'(bus.rvalid), 32'(erv));
      for (int r = 0; r < 3; r++) if (bus.rvalid[r]) rv_cnt[r]++;
      if (bus.rvalid != 3'b000) begin
        if (exp_q.size() == 0) chk($sformatf("rr%0d rdata underrun", c), 32'd1, 32'd0);
        else chk($sformatf("rr%0d rdata", c), 32'(bus.rdata), 32'(exp_q.pop_front()));
      end
    end
    for (int r = 0; r < 3; r++) chk($sformatf("rr rvalid count %0d", r), 32'(rv_cnt[r]), 32'd2);
    chk("rr queue drained", 32'(exp_q.size()), 32'd0);

`ifdef MIX_ARB_GRANT_CNT_EN
    drive(1'b1, 3'b000, 0, 0, 0);
    step();
    chk("cnt reset", 32'(grant_cnt[31:0]), 32'd0);
    for (int c = 0; c < 4; c++) begin
      drive(1'b0, 3'b100, 0, 0, 7);
      step();
    end
    drive(1'b0, 3'b000, 0, 0, 7);
    step();
    chk("cnt req2", 32'(grant_cnt[47:32]), 32'd4);
    chk("cnt req1", 32'(grant_cnt[31:16]), 32'd0);
    chk("cnt req0", 32'(grant_cnt[15:0]),  32'd0);
    drive(1'b0, 3'b100, 0, 0, 7);
    for (int c = 0; c < 65535; c++) step();
    chk("cnt sat", 32'(grant_cnt[47:32]), 32'h0000FFFF);
    step();
    chk("cnt sat hold", 32'(grant_cnt[47:32]), 32'h0000FFFF);
    drive(1'b0, 3'b000, 0, 0, 7);
    step();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
